// File: rtl/math_acc_pkg.sv
// ----------------------------------------------------------------------------
// math_acc_pkg
// Shared types and helpers for the signed accumulator blocks.
//   acc_state_t : two-state handshake FSM used by the accumulators
//   MAX_W       : widest accumulator that sat_add supports
//   sat_add     : width-generic signed add that returns {overflow, clamped sum}
// ----------------------------------------------------------------------------
package math_acc_pkg;

  typedef enum logic {ACC_ACCUM, ACC_DONE} acc_state_t;

  localparam int MAX_W = 64;

  // Adds two 'width'-bit two's complement values that sit in the low bits of
  // MAX_W-bit containers. Bit MAX_W of the result is the signed overflow flag.
  // The low MAX_W bits hold the sum, clamped to the most positive or most
  // negative 'width'-bit value when the add overflows. The sign bit is located
  // with masks rather than a variable bit-select so that any width up to MAX_W works.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] signBit;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] res;
    logic             sa;
    logic             sb;
    logic             ss;
    logic             ovf;
    mask    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    signBit = mask ^ (mask >> 1);
    sum     = (a + b) & mask;
    sa      = |(a & signBit);
    sb      = |(b & signBit);
    ss      = |(sum & signBit);
    ovf     = (sa == sb) && (ss != sa);
    if (!ovf) begin
      res = sum;
    end else if (sa) begin
      res = signBit;
    end else begin
      res = mask >> 1;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/math_acc_sign_extend.sv
// ----------------------------------------------------------------------------
// math_acc_sign_extend
// Sign-extends an IN_W-bit two's complement value to OUT_W bits (OUT_W >= IN_W).
//   i_data : IN_W-bit signed input
//   o_data : OUT_W-bit sign-extended output
// ----------------------------------------------------------------------------
module math_acc_sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data
);

  // A zero-width replication is illegal, so the equal-width case is a plain copy.
  generate
    if (OUT_W > IN_W) begin : g_extend
      assign o_data = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};
    end else begin : g_copy
      assign o_data = i_data;
    end
  endgenerate

endmodule

// File: rtl/math_multiplier_booth_accumulator.sv
// ----------------------------------------------------------------------------
// math_multiplier_booth_accumulator
// Sums groups of signed 2*N-bit Booth products into an ACC_W-bit total and
// hands the result downstream with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous abort of the current group (highest priority)
//   i_product      : signed product, qualified by i_valid, last term by i_last
//   o_ready        : high while collecting terms (ACCUM state)
//   o_sum          : signed group total (registered)
//   o_count        : number of terms in the group, saturating at all-ones
//   o_overflow     : sticky signed-overflow flag for the group
//   o_valid/i_ready: result handshake (DONE state)
//
// Configuration
//   MATH_ACC_SATURATE_EN : when defined, the accumulator clamps on signed
//                          overflow instead of wrapping. Wrap is the default.
//   ACC_W must lie between 2*N and MAX_W (64).
// ----------------------------------------------------------------------------
module math_multiplier_booth_accumulator
  import math_acc_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [2*N-1:0]   i_product,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_valid,
  input  logic             i_ready
);

  acc_state_t       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [ACC_W-1:0] extProduct;
  logic             ovfBeat;

  math_acc_sign_extend #(
    .IN_W  (2*N),
    .OUT_W (ACC_W)
  ) u_sign_extend (
    .i_data (i_product),
    .o_data (extProduct)
  );

  // Overflow detection is shared by both builds; only the sum differs.
  assign ovfBeat = 1'(sat_add(MAX_W'(acc_q), MAX_W'(extProduct), ACC_W) >> MAX_W);

  // Values the registers take when a beat is accepted. The first beat of a
  // group loads rather than adds, so no clear cycle is needed between groups.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
    if (count_q == '0) begin
      acc_d = extProduct;
      ovf_d = 1'b0;
    end else begin
`ifdef MATH_ACC_SATURATE_EN
      acc_d = ACC_W'(sat_add(MAX_W'(acc_q), MAX_W'(extProduct), ACC_W));
`else
      acc_d = acc_q + extProduct;
`endif
      ovf_d = ovf_q | ovfBeat;
    end
  end

  // Group FSM. Clear beats everything and discards same-cycle beats and
  // handshakes. DONE ignores i_valid, so a result handshake never overlaps
  // with an input beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ACC_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (i_clear) begin
      state_q <= ACC_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC_ACCUM: begin
          if (i_valid) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (i_last) begin
              state_q <= ACC_DONE;
            end
          end
        end
        ACC_DONE: begin
          if (i_ready) begin
            state_q <= ACC_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ACC_ACCUM;
      endcase
    end
  end

  assign o_ready    = (state_q == ACC_ACCUM);
  assign o_valid    = (state_q == ACC_DONE);
  assign o_sum      = acc_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_math_multiplier_booth_accumulator.sv
// ----------------------------------------------------------------------------
// tb_math_multiplier_booth_accumulator
// Two instances share clock and reset: dutA uses the default ACC_W (24), and
// dutB uses ACC_W=16 to exercise overflow. Expected group results are pushed
// into per-instance queues. A monitor pops and compares them whenever a
// result handshake occurs.
// ----------------------------------------------------------------------------
module tb_math_multiplier_booth_accumulator;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic        aClear, aValid, aLast, aReadyIn;
  logic [15:0] aProd;
  logic        aReadyOut, aValidOut, aOvf;
  logic [23:0] aSum;
  logic [7:0]  aCount;

  logic        bClear, bValid, bLast, bReadyIn;
  logic [15:0] bProd;
  logic        bReadyOut, bValidOut, bOvf;
  logic [15:0] bSum;
  logic [7:0]  bCount;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  math_multiplier_booth_accumulator #(.N(N)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(aClear), .i_product(aProd),
    .i_valid(aValid), .i_last(aLast), .o_ready(aReadyOut), .o_sum(aSum),
    .o_count(aCount), .o_overflow(aOvf), .o_valid(aValidOut), .i_ready(aReadyIn)
  );

  math_multiplier_booth_accumulator #(.N(N), .ACC_W(16)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(bClear), .i_product(bProd),
    .i_valid(bValid), .i_last(bLast), .o_ready(bReadyOut), .o_sum(bSum),
    .o_count(bCount), .o_overflow(bOvf), .o_valid(bValidOut), .i_ready(bReadyIn)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Waits for o_ready, then presents one beat for exactly one clock edge.
  task automatic applyStimulus(input bit sel, input logic [15:0] p, input logic last);
    int n = 0;
    while (((sel ? bReadyOut : aReadyOut) !== 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("[TB] FAIL readyTimeout: got o_ready=0, expected 1 within 50 cycles");
    end
    if (sel) begin bValid = 1'b1; bProd = p; bLast = last; end
    else     begin aValid = 1'b1; aProd = p; aLast = last; end
    @(posedge clk); #1;
    if (sel) begin bValid = 1'b0; bLast = 1'b0; end
    else     begin aValid = 1'b0; aLast = 1'b0; end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", qA.size() + qB.size());
      qA.delete();
      qB.delete();
    end
  endtask

  // Scoreboard monitors: sample mid-cycle, compare on each result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && aValidOut && aReadyIn) begin
      if (qA.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpectedA: got result 0x%0h, expected none", aSum);
      end else begin
        e = qA.pop_front();
        checkOutput("A.sum", 32'(aSum), 32'(e.sum));
        checkOutput("A.count", 32'(aCount), 32'(e.count));
        checkOutput("A.overflow", 32'(aOvf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bValidOut && bReadyIn) begin
      if (qB.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpectedB: got result 0x%0h, expected none", bSum);
      end else begin
        e = qB.pop_front();
        checkOutput("B.sum", 32'(bSum), 32'(e.sum));
        checkOutput("B.count", 32'(bCount), 32'(e.count));
        checkOutput("B.overflow", 32'(bOvf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    aClear = 1'b0; aValid = 1'b0; aLast = 1'b0; aReadyIn = 1'b1; aProd = '0;
    bClear = 1'b0; bValid = 1'b0; bLast = 1'b0; bReadyIn = 1'b1; bProd = '0;

    // Reset values
    #12;
    checkOutput("reset valid", 32'(aValidOut), 32'd0);
    checkOutput("reset ready", 32'(aReadyOut), 32'd1);
    checkOutput("reset sum", 32'(aSum), 32'd0);
    checkOutput("reset count", 32'(aCount), 32'd0);
    checkOutput("reset overflow", 32'(aOvf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic three-term group: 15 - 14 + 100 = 101, valid one cycle after last
    qA.push_back('{24'd101, 8'd3, 1'b0});
    applyStimulus(0, 16'h000F, 1'b0);
    applyStimulus(0, 16'hFFF2, 1'b0);
    applyStimulus(0, 16'h0064, 1'b1);
    checkOutput("latency valid", 32'(aValidOut), 32'd1);
    @(posedge clk); #1;
    checkOutput("after ack valid", 32'(aValidOut), 32'd0);

    // Backpressure in DONE while i_valid is driven: 16 + (-1) = 15
    aReadyIn = 1'b0;
    qA.push_back('{24'd15, 8'd2, 1'b0});
    applyStimulus(0, 16'h0010, 1'b0);
    applyStimulus(0, 16'hFFFF, 1'b1);
    aValid = 1'b1; aProd = 16'h1234; aLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("stall sum", 32'(aSum), 32'd15);
      checkOutput("stall ready", 32'(aReadyOut), 32'd0);
      checkOutput("stall count", 32'(aCount), 32'd2);
    end
    aValid = 1'b0; aLast = 1'b0; aReadyIn = 1'b1;
    @(posedge clk); #1;
    checkOutput("post ack ready", 32'(aReadyOut), 32'd1);
    checkOutput("post ack count", 32'(aCount), 32'd0);
    qA.push_back('{24'd2, 8'd1, 1'b0});
    applyStimulus(0, 16'h0002, 1'b1);
    waitDrain();

    // Abort a partial group with clear
    applyStimulus(0, 16'h0007, 1'b0);
    applyStimulus(0, 16'h0008, 1'b0);
    checkOutput("pre clear count", 32'(aCount), 32'd2);
    aClear = 1'b1;
    @(posedge clk); #1;
    aClear = 1'b0;
    checkOutput("clear count", 32'(aCount), 32'd0);
    checkOutput("clear sum", 32'(aSum), 32'd0);
    checkOutput("clear valid", 32'(aValidOut), 32'd0);
    qA.push_back('{24'd5, 8'd1, 1'b0});
    applyStimulus(0, 16'h0005, 1'b1);
    waitDrain();

    // Asynchronous reset while holding a result in DONE
    aReadyIn = 1'b0;
    applyStimulus(0, 16'h0009, 1'b1);
    checkOutput("pre reset valid", 32'(aValidOut), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", 32'(aValidOut), 32'd0);
    checkOutput("async reset sum", 32'(aSum), 32'd0);
    checkOutput("async reset ready", 32'(aReadyOut), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    aReadyIn = 1'b1;
    qA.push_back('{24'd5, 8'd1, 1'b0});
    applyStimulus(0, 16'h0005, 1'b1);
    waitDrain();

    // Term counter saturates at 255 while the sum keeps counting to 260
    qA.push_back('{24'd260, 8'd255, 1'b0});
    for (int i = 0; i < 259; i++) applyStimulus(0, 16'h0001, 1'b0);
    applyStimulus(0, 16'h0001, 1'b1);
    waitDrain();

    // ACC_W=16 overflow cases: wrap by default, clamp with the saturate macro
`ifdef MATH_ACC_SATURATE_EN
    qB.push_back('{24'h007FFF, 8'd2, 1'b1});
    qB.push_back('{24'h008000, 8'd2, 1'b1});
    qB.push_back('{24'h007FFE, 8'd3, 1'b1});
`else
    qB.push_back('{24'h008000, 8'd2, 1'b1});
    qB.push_back('{24'h007FFF, 8'd2, 1'b1});
    qB.push_back('{24'h007FFF, 8'd3, 1'b1});
`endif
    applyStimulus(1, 16'h7FFF, 1'b0);
    applyStimulus(1, 16'h0001, 1'b1);
    applyStimulus(1, 16'h8000, 1'b0);
    applyStimulus(1, 16'hFFFF, 1'b1);
    applyStimulus(1, 16'h7FFF, 1'b0);
    applyStimulus(1, 16'h0001, 1'b0);
    applyStimulus(1, 16'hFFFF, 1'b1);
    // Overflow flag must not leak into the next group
    qB.push_back('{24'd3, 8'd1, 1'b0});
    applyStimulus(1, 16'h0003, 1'b1);
    waitDrain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
